quad_encoder_sampler: RTL and testbench

- Decodes one motor's quadrature encoder (A/B) into a signed per-window position delta, i.e. a velocity sample.
- Emits a one-cycle strobe with each sample.
- Sits directly upstream of the encoder IIR low-pass filter: delta_out drives the filter's `in`, sample_valid drives its `en`.
- Also counts illegal (double-bit) encoder transitions for the motor fault path.

---
 rtl/quad_encoder_sampler.sv | 211 +++++++++++++++++++++
 tb/tb_quad_encoder_sampler.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_sampler.sv
// Quadrature encoder sampler: synchronizes A/B, decodes steps, and closes a
// saturating signed step count every SAMPLE_DIV cycles with a one-cycle strobe.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset        asynchronous active-low reset
//   enc_a/enc_b  raw encoder channels, asynchronous to clk
//   err_clear    synchronous clear of enc_err / err_count
//   delta_out    signed step count of the last closed window
//   sample_valid one-cycle pulse when delta_out updates
//   enc_err      sticky illegal-transition flag
//   err_count    saturating illegal-transition counter
module quad_encoder_sampler #(
   parameter int WIDTH       = 16,
   parameter int SAMPLE_DIV  = 18432,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enc_a,
   input  logic             enc_b,
   input  logic             err_clear,
   output logic [WIDTH-1:0] delta_out,
   output logic             sample_valid,
   output logic             enc_err,
   output logic [7:0]       err_count
);

   localparam int CW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam int PW = $clog2(SYNC_STAGES + 2);

   localparam logic [CW-1:0] WIN_LAST   = CW'(SAMPLE_DIV - 1);
   localparam logic [PW-1:0] PRIME_LAST = PW'(SYNC_STAGES);
   localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);

   localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
   logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
   logic [1:0]             prev_q, prev_d;
   logic [PW-1:0]          prime_q, prime_d;
   logic [WIDTH-1:0]       acc_q, acc_d;
   logic [CW-1:0]          win_q, win_d;
   logic [WIDTH-1:0]       delta_q, delta_d;
   logic                   valid_q, valid_d;
   logic                   err_q, err_d;
   logic [7:0]             ecnt_q, ecnt_d;

   // ---------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------
   logic [1:0]       s_w;
   logic [1:0]       diff_w;
   logic             primed_w;
   logic             step_up_w;
   logic             step_dn_w;
   logic             illegal_w;
   logic [WIDTH:0]   step_w;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH-1:0] sat_w;
   logic             term_w;

   // Position of a state along the forward cycle 00->01->11->10.
   function automatic logic [1:0] pos_of(input logic [1:0] ab);
      logic [1:0] p;
      p = 2'd0;
      unique case (ab)
         2'b00: p = 2'd0;
         2'b01: p = 2'd1;
         2'b11: p = 2'd2;
         2'b10: p = 2'd3;
      endcase
      return p;
   endfunction

   // ---------------------------------------------------------------
   // Synchronizers
   // ---------------------------------------------------------------
   always_comb begin
      a_sync_d = {a_sync_q[SYNC_STAGES-2:0], enc_a};
      b_sync_d = {b_sync_q[SYNC_STAGES-2:0], enc_b};
   end

   assign s_w = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

   // ---------------------------------------------------------------
   // Priming and decode
   // ---------------------------------------------------------------
   assign primed_w = (prime_q == PRIME_DONE);

   always_comb begin
      prime_d = primed_w ? prime_q : prime_q + PW'(1);
      prev_d  = prev_q;
      // The last priming cycle seeds prev silently, so an encoder resting
      // at a non-zero state is not mistaken for a jump from 00.
      if (primed_w || (prime_q == PRIME_LAST)) begin
         prev_d = s_w;
      end
   end

   // Distance travelled along the cycle since the last cycle, modulo 4.
   assign diff_w = pos_of(s_w) - pos_of(prev_q);

   always_comb begin
      step_up_w = 1'b0;
      step_dn_w = 1'b0;
      illegal_w = 1'b0;
      if (primed_w) begin
         unique case (diff_w)
            2'd0: ;
            2'd1: step_up_w = 1'b1;
            2'd2: illegal_w = 1'b1;
            2'd3: step_dn_w = 1'b1;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Saturating accumulator
   // ---------------------------------------------------------------
   always_comb begin
      step_w = '0;
      if (step_up_w) begin
         step_w = (WIDTH+1)'(1);
      end else if (step_dn_w) begin
         step_w = '1;
      end
   end

   assign sum_w = {acc_q[WIDTH-1], acc_q} + step_w;

   // One guard bit: overflow when guard and sign disagree.
   always_comb begin
      sat_w = sum_w[WIDTH-1:0];
      if (sum_w[WIDTH] != sum_w[WIDTH-1]) begin
         sat_w = sum_w[WIDTH] ? ACC_MIN : ACC_MAX;
      end
   end

   // ---------------------------------------------------------------
   // Sample window
   // ---------------------------------------------------------------
   assign term_w = (win_q == WIN_LAST);

   always_comb begin
      win_d   = term_w ? '0 : win_q + CW'(1);
      valid_d = term_w;
      // A step decoded on the terminal cycle closes with this window.
      acc_d   = term_w ? '0 : sat_w;
      delta_d = term_w ? sat_w : delta_q;
   end

   // ---------------------------------------------------------------
   // Illegal-transition tracking
   // ---------------------------------------------------------------
   always_comb begin
      err_d  = err_q;
      ecnt_d = ecnt_q;
      if (illegal_w) begin
         // A simultaneous clear restarts the count at this error.
         err_d = 1'b1;
         if (err_clear) begin
            ecnt_d = 8'd1;
         end else if (ecnt_q != 8'hFF) begin
            ecnt_d = ecnt_q + 8'd1;
         end
      end else if (err_clear) begin
         err_d  = 1'b0;
         ecnt_d = 8'd0;
      end
   end

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_sync_q <= '0;
         b_sync_q <= '0;
         prev_q   <= '0;
         prime_q  <= '0;
         acc_q    <= '0;
         win_q    <= '0;
         delta_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         ecnt_q   <= '0;
      end else begin
         a_sync_q <= a_sync_d;
         b_sync_q <= b_sync_d;
         prev_q   <= prev_d;
         prime_q  <= prime_d;
         acc_q    <= acc_d;
         win_q    <= win_d;
         delta_q  <= delta_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         ecnt_q   <= ecnt_d;
      end
   end

   assign delta_out    = delta_q;
   assign sample_valid = valid_q;
   assign enc_err      = err_q;
   assign err_count    = ecnt_q;

endmodule

// File: tb/tb_quad_encoder_sampler.sv
// Bench for quad_encoder_sampler: WIDTH=16 and WIDTH=4 instances share
// stimulus; window deltas are scoreboarded, errors and resets hand-checked.
module tb_quad_encoder_sampler;

   localparam int DIV = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        enc_a;
   logic        enc_b;
   logic        err_clear;
   logic [15:0] d16;
   logic [3:0]  d4;
   logic        sv16, sv4;
   logic        err16, err4;
   logic [7:0]  ec16, ec4;

   always #5 clk = ~clk;

   quad_encoder_sampler #(
      .WIDTH(16), .SAMPLE_DIV(DIV), .SYNC_STAGES(2)
   ) dut16 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .err_clear(err_clear), .delta_out(d16), .sample_valid(sv16),
      .enc_err(err16), .err_count(ec16)
   );

   quad_encoder_sampler #(
      .WIDTH(4), .SAMPLE_DIV(DIV), .SYNC_STAGES(2)
   ) dut4 (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
      .err_clear(err_clear), .delta_out(d4), .sample_valid(sv4),
      .enc_err(err4), .err_count(ec4)
   );

   typedef struct {
      logic [15:0] e16;
      logic [3:0]  e4;
   } exp_t;

   typedef struct {
      int          n;
      int          dir;
      int          hold;
      logic [15:0] e16;
      logic [3:0]  e4;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[7];

   int pass_cnt = 0;
   int total    = 0;
   int cyc      = 0;
   int last_cyc = 0;
   bit armed    = 1'b0;
   int pos      = 2;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] gray(input int p);
      logic [1:0] g;
      case (p & 3)
         0:       g = 2'b00;
         1:       g = 2'b01;
         2:       g = 2'b11;
         default: g = 2'b10;
      endcase
      return g;
   endfunction

   task automatic drive(input int d);
      pos = (pos + d) & 3;
      {enc_a, enc_b} = gray(pos);
   endtask

   task automatic wait_strobe();
      int n;
      n = 0;
      @(negedge clk);
      while (!sv16 && n < 3*DIV) begin
         @(negedge clk);
         n++;
      end
      if (!sv16) begin
         total++;
         $display("FAIL strobe_timeout: none in %0d cycles", 3*DIV);
      end
      #1;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_d16"},  d16,   0);
      chk({tag, "_d4"},   d4,    0);
      chk({tag, "_sv16"}, sv16,  0);
      chk({tag, "_sv4"},  sv4,   0);
      chk({tag, "_err"},  err16, 0);
      chk({tag, "_ec"},   ec16,  0);
      chk({tag, "_ec4"},  ec4,   0);
   endtask

   task automatic check_err(input string tag, input logic e,
                            input logic [7:0] c);
      chk({tag, "_err16"}, err16, e);
      chk({tag, "_err4"},  err4,  e);
      chk({tag, "_ec16"},  ec16,  c);
      chk({tag, "_ec4"},   ec4,   c);
   endtask

   always @(posedge clk) cyc++;

   // Strobe checker: period, pairing and scoreboarded deltas.
   always @(negedge clk) begin
      exp_t e;
      if (armed && reset && (sv16 || sv4)) begin
         chk("strobe_sv16", sv16, 1);
         chk("strobe_sv4", sv4, 1);
         chk("period", cyc - last_cyc, DIV);
         last_cyc = cyc;
         if (sb.size() > 0) e = sb.pop_front();
         else e = '{16'h0000, 4'h0};
         chk("delta16", d16, e.e16);
         chk("delta4", d4, e.e4);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{5,  1, 2, 16'h0005, 4'h5};
      tbl[1] = '{0,  1, 1, 16'h0000, 4'h0};
      tbl[2] = '{3, -1, 2, 16'hFFFD, 4'hD};
      tbl[3] = '{10, 1, 1, 16'h000A, 4'h7};
      tbl[4] = '{12, -1, 1, 16'hFFF4, 4'h8};
      tbl[5] = '{7,  1, 1, 16'h0007, 4'h7};
      tbl[6] = '{8, -1, 1, 16'hFFF8, 4'h8};

      reset = 1'b0;
      err_clear = 1'b0;
      pos = 2;
      {enc_a, enc_b} = gray(pos);
      repeat (3) @(negedge clk);
      #1;
      check_zero("reset");
      last_cyc = cyc;
      reset = 1'b1;
      armed = 1'b1;

      // Resting at 11 through priming must not flag an error.
      wait_strobe();
      check_err("prime", 1'b0, 8'd0);
      wait_strobe();

      foreach (tbl[i]) begin
         wait_strobe();
         sb.push_back('{tbl[i].e16, tbl[i].e4});
         for (int k = 0; k < tbl[i].n; k++) begin
            drive(tbl[i].dir);
            repeat (tbl[i].hold) @(negedge clk);
            #1;
         end
      end
      wait_strobe();

      // Single illegal jump.
      wait_strobe();
      drive(2);
      repeat (5) @(negedge clk);
      #1;
      check_err("illegal1", 1'b1, 8'd1);

      // Clear on the very cycle the second illegal decodes.
      drive(2);
      repeat (2) @(negedge clk);
      #1;
      err_clear = 1'b1;
      @(negedge clk);
      #1;
      err_clear = 1'b0;
      check_err("clr_vs_err", 1'b1, 8'd1);

      err_clear = 1'b1;
      @(negedge clk);
      #1;
      err_clear = 1'b0;
      check_err("clr_alone", 1'b0, 8'd0);

      // Counter saturation.
      repeat (260) begin
         drive(2);
         @(negedge clk);
         #1;
      end
      repeat (4) @(negedge clk);
      #1;
      check_err("err_sat", 1'b1, 8'd255);
      err_clear = 1'b1;
      @(negedge clk);
      #1;
      err_clear = 1'b0;
      check_err("sat_clr", 1'b0, 8'd0);

      // Step decoded exactly on the terminal cycle.
      wait_strobe();
      sb.push_back('{16'h0001, 4'h1});
      repeat (13) @(negedge clk);
      #1;
      drive(1);
      wait_strobe();
      wait_strobe();

      // Mid-window reset.
      wait_strobe();
      sb.push_back('{16'h0002, 4'h2});
      drive(1);
      @(negedge clk);
      #1;
      drive(1);
      wait_strobe();
      drive(2);
      @(negedge clk);
      #1;
      drive(1);
      repeat (6) @(negedge clk);
      #1;
      chk("pre_rst_d16", d16, 16'h0002);
      chk("pre_rst_err", err16, 1);
      reset = 1'b0;
      #1;
      check_zero("midrst");
      sb.delete();
      repeat (3) @(negedge clk);
      #1;
      check_zero("midrst_hold");
      last_cyc = cyc;
      reset = 1'b1;
      wait_strobe();
      check_err("reprime", 1'b0, 8'd0);
      wait_strobe();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
